// File: rtl/mult_div_ctrl_if.sv
// mult_div_ctrl_if
//   Request/response bundle between the main controller and the multiply/divide
//   unit.
//
//   Handshake: start_mult / start_div act as "valid". The unit is "ready" only
//   while its FSM is IDLE, which is exactly when busy is low. A start is
//   accepted on a rising edge where valid is high and the unit is IDLE. Starts
//   at any other time are dropped without side effects, so the requester must
//   hold its start until it sees busy rise. a_in/b_in only need to be valid on
//   the accepting edge. done pulses for one cycle once hi/lo (or div_zero) are
//   final. While done is high, busy is still high.
//
//   master : controller side (drives starts and operands)
//   slave  : mult/div unit side (drives busy, done, div_zero, hi, lo)
interface mult_div_ctrl_if;
  logic        start_mult;
  logic        start_div;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start_mult, start_div, a_in, b_in,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start_mult, start_div, a_in, b_in,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl
//   Multi-cycle signed multiply/divide unit that owns the HI/LO registers.
//   Multiply uses radix-2 Booth recoding over 32 iterations. Divide uses
//   unsigned restoring division on operand magnitudes over 32 iterations,
//   followed by a sign fix-up. HI/LO are written only on the FIX->DONE edge.
//
//   Ports:
//     clk      : system clock, rising edge
//     rst      : asynchronous, active-low reset
//     bus      : mult_div_ctrl_if.slave (starts, operands, busy/done/div_zero, hi/lo)
//     dbgState : current FSM state (IDLE=0, MULT=1, DIV=2, FIX=3, DONE=4)
module mult_div_ctrl (
  input  logic              clk,
  input  logic              rst,
  mult_div_ctrl_if.slave    bus,
  output logic [2:0]        dbgState
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MULT = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t      state;
  // Multiply: {upper partial product, multiplier being shifted out}.
  // Divide:   {partial remainder, dividend shifting into quotient}.
  logic [63:0] acc;
  logic [31:0] mcand;   // multiplicand, or divisor magnitude
  logic        qm1;     // Booth's extra bit to the right of acc[0]
  logic [4:0]  cnt;
  logic        isDiv;
  logic        qNeg;
  logic        rNeg;

  logic [31:0] aMag;
  logic [31:0] bMag;
  logic [32:0] upperExt;
  logic [63:0] boothNext;
  logic [32:0] divShift;
  logic [31:0] divDiff;
  logic [63:0] divNext;

  assign dbgState = state;

  always_comb begin
    aMag = bus.a_in[31] ? (32'd0 - bus.a_in) : bus.a_in;
    bMag = bus.b_in[31] ? (32'd0 - bus.b_in) : bus.b_in;

    // The upper half is widened to 33 bits so that adding or subtracting a
    // most-negative multiplicand cannot overflow before the arithmetic shift.
    upperExt = {acc[63], acc[63:32]};
    case ({acc[0], qm1})
      2'b01:   upperExt = upperExt + {mcand[31], mcand};
      2'b10:   upperExt = upperExt - {mcand[31], mcand};
      default: upperExt = {acc[63], acc[63:32]};
    endcase
    boothNext = {upperExt, acc[31:1]};

    // Restoring step: shift the next dividend bit into the remainder. The
    // difference always fits in 32 bits whenever the subtraction is kept.
    divShift = acc[63:31];
    divDiff  = divShift[31:0] - mcand;
    if (divShift >= {1'b0, mcand}) begin
      divNext = {divDiff, acc[30:0], 1'b1};
    end else begin
      divNext = {divShift[31:0], acc[30:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      acc          <= '0;
      mcand        <= '0;
      qm1          <= 1'b0;
      cnt          <= '0;
      isDiv        <= 1'b0;
      qNeg         <= 1'b0;
      rNeg         <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.div_zero <= 1'b0;
      bus.hi       <= '0;
      bus.lo       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_mult) begin
            acc          <= {32'd0, bus.b_in};
            mcand        <= bus.a_in;
            qm1          <= 1'b0;
            cnt          <= 5'd31;
            isDiv        <= 1'b0;
            bus.busy     <= 1'b1;
            bus.div_zero <= 1'b0;
            state        <= MULT;
          end else if (bus.start_div) begin
            if (bus.b_in == 32'd0) begin
              // Nothing to compute: report straight away and leave hi/lo alone.
              bus.busy     <= 1'b1;
              bus.done     <= 1'b1;
              bus.div_zero <= 1'b1;
              state        <= DONE;
            end else begin
              acc          <= {32'd0, aMag};
              mcand        <= bMag;
              qNeg         <= bus.a_in[31] ^ bus.b_in[31];
              rNeg         <= bus.a_in[31];
              cnt          <= 5'd31;
              isDiv        <= 1'b1;
              bus.busy     <= 1'b1;
              bus.div_zero <= 1'b0;
              state        <= DIV;
            end
          end
        end

        MULT: begin
          acc <= boothNext;
          qm1 <= acc[0];
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) state <= FIX;
        end

        DIV: begin
          acc <= divNext;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) state <= FIX;
        end

        FIX: begin
          if (isDiv) begin
            bus.lo <= qNeg ? (32'd0 - acc[31:0])  : acc[31:0];
            bus.hi <= rNeg ? (32'd0 - acc[63:32]) : acc[63:32];
          end else begin
            bus.lo <= acc[31:0];
            bus.hi <= acc[63:32];
          end
          bus.done <= 1'b1;
          state    <= DONE;
        end

        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
